// File: rtl/vmem_arb_pkg.sv
// ============================================================================
// Module      : vmem_arb_pkg
// Description : Shared defaults, request record and round-robin helper for
//               the video-memory port arbiter and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vmem_arb_pkg;

    localparam int NUM_REQ_DEF    = 3;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LOCK_MAX_DEF   = 8;

    // Requester-side view of one access at the default port widths.
    typedef struct packed {
        logic [DATA_WIDTH_DEF/8-1:0] we;
        logic [ADDR_WIDTH_DEF-1:0]   addr;
        logic [DATA_WIDTH_DEF-1:0]   wdata;
    } vmem_req_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vmem_port_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first valid requester at or
//               after the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap keeps candidates below NUM_REQ for non-power-of-two sizes.
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!any_valid && valid[w_cand]) begin
                any_valid     = 1'b1;
                idx           = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vmem_port_arbiter.sv
// ============================================================================
// Module      : vmem_port_arbiter
// Description : Round-robin arbiter sharing video unit port A between
//               NUM_REQ requesters; fixed 1-cycle response routing.
//               Optional grant locking enabled by macro VMEM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vmem_port_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic                            clk_a,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]              req_lock,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            mem_en,
    output logic [DATA_WIDTH/8-1:0]         mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_write,
    input  logic [DATA_WIDTH-1:0]           mem_read
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_next;
    logic               w_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .idx       (w_idx),
        .any_valid (w_any)
    );

    assign w_next = IDX_W'(rr_next(32'(w_idx), 32'(NUM_REQ)));

    // One-hot AND-OR mux; all outputs fall to zero when nobody is granted.
    always_comb begin
        mem_we    = '0;
        mem_addr  = '0;
        mem_write = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mem_we    = req_we[i*BE_W +: BE_W];
                mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_write = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready = w_grant;
    assign mem_en    = w_any;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = mem_read;

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= w_grant;
        end
    end

`ifdef VMEM_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);

    logic [LCW-1:0]   r_lock_cnt;
    logic [IDX_W-1:0] r_lock_owner;
    logic             r_lock_owner_vld;
    logic [LCW-1:0]   w_cnt_eff;
    logic             w_hold;

    // A grant to a new owner starts a fresh burst count.
    assign w_cnt_eff = (r_lock_owner_vld && (r_lock_owner == w_idx)) ? r_lock_cnt : '0;
    assign w_hold    = req_lock[w_idx] && (w_cnt_eff != LCW'(LOCK_MAX - 1));

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            r_rr_ptr         <= '0;
            r_lock_cnt       <= '0;
            r_lock_owner     <= '0;
            r_lock_owner_vld <= 1'b0;
        end else if (w_any) begin
            if (w_hold) begin
                r_rr_ptr         <= w_idx;
                r_lock_cnt       <= w_cnt_eff + 1'b1;
                r_lock_owner     <= w_idx;
                r_lock_owner_vld <= 1'b1;
            end else begin
                r_rr_ptr         <= w_next;
                r_lock_cnt       <= '0;
                r_lock_owner_vld <= 1'b0;
            end
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= w_next;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vmem_port_arbiter.sv
// ============================================================================
// Module      : tb_vmem_port_arbiter
// Description : Directed self-checking bench for vmem_port_arbiter with a
//               small video-memory model behind the mem_* port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vmem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WW = DW / 8;

    logic              clk_a = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WW-1:0]   req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_lock;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              mem_en;
    logic [WW-1:0]     mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_write;
    logic [DW-1:0]     mem_read;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk_a = ~clk_a;

    vmem_port_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOCK_MAX   (8)
    ) dut (
        .clk_a     (clk_a),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_read  (mem_read)
    );

    // Video memory model: bit 15 plus the low byte of the address select a word.
    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] r_rd;

    function automatic logic [8:0] mkey(input logic [AW-1:0] a);
        return {a[15], a[7:0]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [WW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < WW; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk_a) begin
        if (rst) begin
            for (int k = 0; k < 512; k++) begin
                mem[k] <= {16'hC0DE, k[8], 7'b0, k[7:0]};
            end
            mem[mkey(16'h0010)] <= 32'hDEADBEEF;
            mem[mkey(16'h8002)] <= 32'h12345678;
        end else if (mem_en) begin
            if (|mem_we) mem[mkey(mem_addr)] <= merge(mem[mkey(mem_addr)], mem_write, mem_we);
            r_rd <= mem[mkey(mem_addr)];
        end
    end

    assign mem_read = r_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WW-1:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i*WW +: WW]    = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_lock  = '0;
    endtask

    task automatic do_reset();
        clr_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g_seq [0:3];
        int           id_seq [0:3];

        rst = 1'b1;
        clr_all();
        tick();
        tick();
        tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_mem_en", 32'(mem_en), 32'h0);
        chk("reset_mem_we", 32'(mem_we), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_mem_en", 32'(mem_en), 32'h0);

        // Single read by requester 1, zero-wait grant
        set_req(1, 4'h0, 16'h0010, 32'h0);
        #1;
        chk("t1_ready", 32'(req_ready), 32'h2);
        chk("t1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_mem_we", 32'(mem_we), 32'h0);
        tick();
        clr_all();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

        // Write to control register by requester 2, then read back by requester 0
        set_req(2, 4'hF, 16'h8002, 32'h0);
        #1;
        chk("t3_ready", 32'(req_ready), 32'h4);
        chk("t3_mem_we", 32'(mem_we), 32'hF);
        chk("t3_mem_write", mem_write, 32'h0);
        chk("t3_mem_addr", 32'(mem_addr), 32'h8002);
        tick();
        clr_all();
        chk("t3_wr_rsp", 32'(rsp_valid), 32'h4);
        set_req(0, 4'h0, 16'h8002, 32'h0);
        #1;
        chk("t3_rd_ready", 32'(req_ready), 32'h1);
        tick();
        clr_all();
        chk("t3_rd_rsp", 32'(rsp_valid), 32'h1);
        chk("t3_rd_data", rsp_rdata, 32'h0);
        tick();
        chk("t3_idle_rsp", 32'(rsp_valid), 32'h0);

        // All three valid after reset: rotating grants and ordered responses
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'h0, 16'h0020 + 16'(i), 32'h0);
        g_seq  = '{3'b001, 3'b010, 3'b100, 3'b001};
        id_seq = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_ready", 32'(req_ready), 32'(g_seq[k]));
            chk("t2_mem_addr", 32'(mem_addr), 32'h0020 + 32'(id_seq[k]));
            tick();
            chk("t2_rsp_valid", 32'(rsp_valid), 32'(g_seq[k]));
            chk("t2_rsp_rdata", rsp_rdata, {16'hC0DE, 16'h0020 + 16'(id_seq[k])});
        end
        clr_all();

        // Requester 0 held, requester 1 joins in cycle 2 and is served at once
        do_reset();
        g_seq = '{3'b001, 3'b010, 3'b001, 3'b001};
        set_req(0, 4'h0, 16'h0030, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) set_req(1, 4'h0, 16'h0031, 32'h0);
            #1;
            chk("t4_ready", 32'(req_ready), 32'(g_seq[k]));
            tick();
            if (g_seq[k][1]) req_valid[1] = 1'b0;
        end
        clr_all();

        // Reset while a read is being accepted: no response, pointer back to 0
        do_reset();
        set_req(2, 4'h0, 16'h0040, 32'h0);
        #1;
        chk("t5_ready", 32'(req_ready), 32'h4);
        @(negedge clk_a);
        rst = 1'b1;
        tick();
        chk("t5_rsp_suppressed", 32'(rsp_valid), 32'h0);
        clr_all();
        rst = 1'b0;
        tick();
        chk("t5_rsp_after", 32'(rsp_valid), 32'h0);
        for (int i = 0; i < N; i++) set_req(i, 4'h0, 16'h0050 + 16'(i), 32'h0);
        #1;
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        clr_all();

        // Requester 0 asks to keep its grant while the others wait
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'h0, 16'h0060 + 16'(i), 32'h0);
        req_lock = 3'b001;
`ifdef VMEM_ARB_LOCK_EN
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t6_locked_grant", 32'(req_ready), 32'h1);
            tick();
        end
        #1;
        chk("t6_after_lock", 32'(req_ready), 32'h2);
`else
        g_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_lock_ignored", 32'(req_ready), 32'(g_seq[k]));
            tick();
        end
`endif
        clr_all();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
